led_chaser_ctrl: RTL

//  Sequencer that shares one period counter across N_LED pulse channels, chaser style.
//  - Each step lasts T_PERIOD clocks; exactly one LED, the active index, is eligible per step.
//  - The active LED is driven high during the window [ON_START, ON_END) of the step counter.
//  - Runs a programmed number of loops, then pulses Done_Sig. Sits between board control logic and the LED pins.

---
 rtl/led_pkg.sv | 14 +
 rtl/led_step_timer.sv | 34 +++
 rtl/led_chaser_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/led_pkg.sv
// Shared types and default timing constants for the LED chaser.
package led_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } led_state_e;

    localparam int unsigned T100MS       = 2_000_000;
    localparam int unsigned ON_START_DEF = 500_000;
    localparam int unsigned ON_END_DEF   = 1_000_000;

endpackage

// File: rtl/led_step_timer.sv
// Step counter 0..T_PERIOD-1 with clear/enable, plus step-end and lit-window flags.
module led_step_timer
    import led_pkg::*;
#(
    parameter  int unsigned T_PERIOD = T100MS,
    parameter  int unsigned ON_START = ON_START_DEF,
    parameter  int unsigned ON_END   = ON_END_DEF,
    localparam int unsigned CNT_W    = $clog2(T_PERIOD)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] Count,
    output logic             step_end,
    output logic             in_window
);

    // Decode position within the step; compared at 32 bits so ON_END may equal T_PERIOD.
    always_comb begin
        step_end  = (32'(Count) == T_PERIOD - 1);
        in_window = (32'(Count) >= ON_START) && (32'(Count) < ON_END);
    end

    // Free-running step counter, wrapping at the end of each step.
    always_ff @(posedge CLK) begin
        if (RST || clr) begin
            Count <= '0;
        end else if (en) begin
            Count <= step_end ? '0 : Count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/led_chaser_ctrl.sv
// LED chaser sequencer: one shared step timer, one active LED per step,
// programmed loop count, Done_Sig pulse at completion.
// Optional macro LED_CHASER_PINGPONG_EN: index bounces between the ends instead of wrapping.
module led_chaser_ctrl
    import led_pkg::*;
#(
    parameter int unsigned T_PERIOD = T100MS,
    parameter int unsigned ON_START = ON_START_DEF,
    parameter int unsigned ON_END   = ON_END_DEF,
    parameter int unsigned N_LED    = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Start_Sig,
    input  logic             Stop_Sig,
    input  logic             Dir,
    input  logic [3:0]       Loop_Num,
    output logic             Busy,
    output logic             Done_Sig,
    output logic [N_LED-1:0] LED_Out
);

    localparam int unsigned CNT_W  = $clog2(T_PERIOD);
    localparam int unsigned IDX_W  = $clog2(N_LED);
    localparam int unsigned STEP_W = $clog2(2 * N_LED);
`ifdef LED_CHASER_PINGPONG_EN
    localparam int unsigned STEPS_PER_LOOP = 2 * N_LED - 2;
`else
    localparam int unsigned STEPS_PER_LOOP = N_LED;
`endif
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_LED - 1);

    led_state_e        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [3:0]        loop_cnt_q, loop_cnt_d;
    logic [3:0]        loop_num_q, loop_num_d;
    logic              dir_q, dir_d;

    logic              step_end;
    logic              in_window;
    logic [CNT_W-1:0]  unused_step_cnt;

    led_step_timer #(
        .T_PERIOD (T_PERIOD),
        .ON_START (ON_START),
        .ON_END   (ON_END)
    ) u_timer (
        .CLK       (CLK),
        .RST       (RST),
        .clr       (state_q != RUN),
        .en        (state_q == RUN),
        .Count     (unused_step_cnt),
        .step_end  (step_end),
        .in_window (in_window)
    );

    // Next-state logic: start capture, step/loop bookkeeping, index advance; Stop overrides all.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        step_d     = step_q;
        loop_cnt_d = loop_cnt_q;
        loop_num_d = loop_num_q;
        dir_d      = dir_q;
        case (state_q)
            IDLE: begin
                if (Start_Sig) begin
                    state_d    = RUN;
                    idx_d      = Dir ? LAST_IDX : '0;
                    dir_d      = Dir;
                    loop_num_d = Loop_Num;
                    loop_cnt_d = '0;
                    step_d     = '0;
                end
            end
            RUN: begin
                if (step_end) begin
                    if (step_q == STEP_W'(STEPS_PER_LOOP - 1)) begin
                        step_d = '0;
                        if ((loop_num_q != 4'd0) && (loop_cnt_q == loop_num_q - 4'd1)) begin
                            state_d = FINISH;
                        end else if (loop_num_q != 4'd0) begin
                            loop_cnt_d = loop_cnt_q + 4'd1;
                        end
                    end else begin
                        step_d = step_q + STEP_W'(1);
                    end
                    if (state_d == RUN) begin
`ifdef LED_CHASER_PINGPONG_EN
                        if (!dir_q) begin
                            if (idx_q == LAST_IDX) begin
                                idx_d = idx_q - IDX_W'(1);
                                dir_d = 1'b1;
                            end else begin
                                idx_d = idx_q + IDX_W'(1);
                            end
                        end else begin
                            if (idx_q == '0) begin
                                idx_d = idx_q + IDX_W'(1);
                                dir_d = 1'b0;
                            end else begin
                                idx_d = idx_q - IDX_W'(1);
                            end
                        end
`else
                        if (!dir_q) begin
                            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
                        end else begin
                            idx_d = (idx_q == '0) ? LAST_IDX : idx_q - IDX_W'(1);
                        end
`endif
                    end
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (Stop_Sig) begin
            state_d = IDLE;
        end
    end

    // Sequencer state registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            step_q     <= '0;
            loop_cnt_q <= '0;
            loop_num_q <= '0;
            dir_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            step_q     <= step_d;
            loop_cnt_q <= loop_cnt_d;
            loop_num_q <= loop_num_d;
            dir_q      <= dir_d;
        end
    end

    // Registered outputs; Stop clears LED and suppresses Done at the same edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            Busy     <= 1'b0;
            Done_Sig <= 1'b0;
            LED_Out  <= '0;
        end else begin
            Busy     <= (state_d == RUN);
            Done_Sig <= (state_q == FINISH) && !Stop_Sig;
            LED_Out  <= ((state_q == RUN) && in_window && !Stop_Sig) ? (N_LED'(1) << idx_q) : '0;
        end
    end

endmodule
